ncc_sequencer: RTL and testbench

Controller that sequences the 16x16 NCC processing-element grid for one match job. It loads the 64 packed descriptor words into the grid row by row, then streams window pixels through it, driving the PE load enables. It emits one correlation result strobe per window position, with index and backpressure, and sits between the descriptor/window stream sources and the PE array plus result sink.

---
 rtl/ncc_sequencer.sv | 148 ++++++++++++++
 tb/tb_ncc_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ncc_sequencer.sv
// NCC grid sequencer: descriptor load, window streaming and result handshake
// for one match job over the PE array.
module ncc_sequencer #(
    parameter int GRID_ROWS    = 16,
    parameter int GRID_COLS    = 16,
    parameter int PIX_PER_WORD = 4,
    parameter int WIN_PIXELS   = 640,
    parameter int CW           = $clog2(WIN_PIXELS + 1)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic                                       reuse_desc,
    input  logic                                       desc_valid,
    output logic                                       desc_ready,
    output logic                                       desc_load,
    output logic [$clog2(GRID_ROWS)-1:0]               desc_row,
    output logic [$clog2(GRID_COLS/PIX_PER_WORD)-1:0]  desc_col_group,
    input  logic                                       win_valid,
    output logic                                       win_ready,
    output logic                                       load_win,
    output logic                                       load_acc,
    output logic                                       result_valid,
    input  logic                                       result_ready,
    output logic [CW-1:0]                              result_idx,
    output logic                                       busy,
    output logic                                       done
);

    localparam int GROUPS = GRID_COLS / PIX_PER_WORD;
    localparam int RW     = $clog2(GRID_ROWS);
    localparam int GW     = $clog2(GROUPS);

    localparam logic [RW-1:0] ROW_LAST = RW'(GRID_ROWS - 1);
    localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);
    localparam logic [CW-1:0] K_LAST   = CW'(WIN_PIXELS - 1);
    // accepting a pixel while k >= K_FIRST fills the grid and yields a result
    localparam logic [CW-1:0] K_FIRST  = CW'(GRID_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DESC,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          desc_resident;
    logic [CW-1:0] kcnt;
    logic          last_word;
    logic          last_pix;

    assign last_word = desc_load && (desc_row == ROW_LAST)
                       && (desc_col_group == GRP_LAST);
    assign last_pix  = load_win && (kcnt == K_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (reuse_desc && desc_resident) ? S_STREAM : S_DESC;
                end
            end
            S_DESC: begin
                if (last_word) state_nx = S_STREAM;
            end
            S_STREAM: begin
                if (last_pix) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (!result_valid || result_ready) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        desc_ready = (state == S_DESC);
        desc_load  = desc_ready && desc_valid;
        win_ready  = (state == S_STREAM) && (!result_valid || result_ready);
        load_win   = win_ready && win_valid;
        load_acc   = load_win;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            desc_row       <= '0;
            desc_col_group <= '0;
            desc_resident  <= 1'b0;
            kcnt           <= '0;
            result_valid   <= 1'b0;
            result_idx     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            busy <= (state_nx != S_IDLE);
            done <= (state_nx == S_DONE);

            if (state == S_IDLE && start) begin
                desc_row       <= '0;
                desc_col_group <= '0;
                kcnt           <= '0;
            end

            if (desc_load) begin
                if (desc_col_group == GRP_LAST) begin
                    desc_col_group <= '0;
                    if (desc_row == ROW_LAST) begin
                        desc_row      <= '0;
                        desc_resident <= 1'b1;
                    end else begin
                        desc_row <= desc_row + 1'b1;
                    end
                end else begin
                    desc_col_group <= desc_col_group + 1'b1;
                end
            end

            if (load_win) begin
                kcnt <= kcnt + 1'b1;
            end

            if (load_win && (kcnt >= K_FIRST)) begin
                result_valid <= 1'b1;
                result_idx   <= kcnt - K_FIRST;
            end else if (result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ncc_sequencer.sv
// Scoreboard bench for ncc_sequencer: descriptor mapping, result ordering,
// stalls, reset mid-job and descriptor reuse.
module tb_ncc_sequencer;

    localparam int ROWS   = 16;
    localparam int COLS   = 16;
    localparam int PPW    = 4;
    localparam int WIN    = 640;
    localparam int CW     = $clog2(WIN + 1);
    localparam int GROUPS = COLS / PPW;
    localparam int NRES   = WIN - COLS + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          reuse_desc = 1'b0;
    logic          desc_valid = 1'b0;
    logic          win_valid = 1'b0;
    logic          result_ready = 1'b0;
    logic          desc_ready;
    logic          desc_load;
    logic [3:0]    desc_row;
    logic [1:0]    desc_col_group;
    logic          win_ready;
    logic          load_win;
    logic          load_acc;
    logic          result_valid;
    logic [CW-1:0] result_idx;
    logic          busy;
    logic          done;

    ncc_sequencer #(
        .GRID_ROWS   (ROWS),
        .GRID_COLS   (COLS),
        .PIX_PER_WORD(PPW),
        .WIN_PIXELS  (WIN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .reuse_desc    (reuse_desc),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_load     (desc_load),
        .desc_row      (desc_row),
        .desc_col_group(desc_col_group),
        .win_valid     (win_valid),
        .win_ready     (win_ready),
        .load_win      (load_win),
        .load_acc      (load_acc),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_idx    (result_idx),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_desc  = 0;
    int n_pix   = 0;
    int n_res   = 0;
    int n_done  = 0;
    int dcnt    = 0;
    int kpix    = 0;
    int q[$];
    int d0, p0, r0, n0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+1, so the negedge sees exactly what the
    // next posedge will act on.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            kpix = 0;
            dcnt = 0;
        end else begin
            if (start && !busy) begin
                dcnt = 0;
                kpix = 0;
            end
            if (desc_valid) chk("desc_load", int'(desc_load), int'(desc_ready));
            if (load_win || load_acc) chk("load_acc", int'(load_acc), int'(load_win));
            if (desc_load) begin
                chk("desc_row", int'(desc_row), dcnt / GROUPS);
                chk("desc_grp", int'(desc_col_group), dcnt % GROUPS);
                dcnt++;
                n_desc++;
            end
            if (result_valid) begin
                if (q.size() == 0) begin
                    chk("res_unexpected", int'(result_idx), -1);
                end else begin
                    chk("res_idx", int'(result_idx), q[0]);
                    if (result_ready) begin
                        void'(q.pop_front());
                        n_res++;
                    end
                end
            end
            if (load_win) begin
                kpix++;
                n_pix++;
                if (kpix >= COLS) q.push_back(kpix - COLS);
            end
            if (done) n_done++;
        end
    end

    task automatic snap();
        d0 = n_desc;
        p0 = n_pix;
        r0 = n_res;
        n0 = n_done;
    endtask

    task automatic job_checks(input string nm, input int exp_desc);
        @(posedge clk);
        #1;
        chk({nm, "_desc"}, n_desc - d0, exp_desc);
        chk({nm, "_pix"}, n_pix - p0, WIN);
        chk({nm, "_res"}, n_res - r0, NRES);
        chk({nm, "_done"}, n_done - n0, 1);
        chk({nm, "_qempty"}, q.size(), 0);
        chk({nm, "_idle"}, int'(busy), 0);
    endtask

    task automatic run_job(input string nm, input bit reuse, input int dmode,
                           input int wmode, input bit stall, input int rst_at,
                           output int cyc);
        int gap;
        int held;
        gap  = 0;
        held = 0;
        start        = 1'b1;
        reuse_desc   = reuse;
        desc_valid   = 1'b1;
        win_valid    = 1'b1;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        reuse_desc = 1'b0;
        cyc = 1;
        while (!done && cyc < 4000) begin
            desc_valid = (dmode == 0) ? 1'b1 : (cyc % 2 == 1);
            start      = (dmode == 1) && (cyc % 7 == 3);
            reuse_desc = start;
            if (wmode == 0) begin
                win_valid = 1'b1;
            end else if (gap > 0) begin
                win_valid = 1'b0;
                gap--;
            end else begin
                win_valid = 1'b1;
                if ($urandom_range(0, 3) == 0) gap = int'($urandom_range(1, 6));
            end
            result_ready = 1'b1;
            if (stall && result_valid && result_idx == CW'(100) && held < 5) begin
                result_ready = 1'b0;
                held++;
                #1;
                chk("stall_wr", int'(win_ready), 0);
                chk("stall_idx", int'(result_idx), 100);
            end
            if (rst_at > 0 && kpix >= rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk("rst_rv", int'(result_valid), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_idx", int'(result_idx), 0);
                chk("rst_wr", int'(win_ready), 0);
                chk("rst_lw", int'(load_win), 0);
                rst        = 1'b0;
                start      = 1'b0;
                desc_valid = 1'b0;
                win_valid  = 1'b0;
                cyc = 0;
                return;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) chk({nm, "_timeout"}, 0, 1);
        chk({nm, "_stall_cnt"}, held, stall ? 5 : 0);
        start      = 1'b0;
        reuse_desc = 1'b0;
        desc_valid = 1'b0;
        win_valid  = 1'b0;
    endtask

    initial begin
        int c;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_rv", int'(result_valid), 0);
        chk("reset_dr", int'(desc_ready), 0);
        chk("reset_wr", int'(win_ready), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_idx", int'(result_idx), 0);
        chk("reset_row", int'(desc_row), 0);
        chk("reset_grp", int'(desc_col_group), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        snap();
        run_job("full", 1'b0, 0, 0, 1'b0, 0, c);
        chk("full_cycles", c, 706);
        job_checks("full", 64);

        snap();
        run_job("reuse", 1'b1, 0, 0, 1'b0, 0, c);
        chk("reuse_cycles", c, 642);
        job_checks("reuse", 0);

        snap();
        run_job("stall", 1'b1, 0, 0, 1'b1, 0, c);
        job_checks("stall", 0);

        snap();
        run_job("toggle", 1'b0, 1, 0, 1'b0, 0, c);
        job_checks("toggle", 64);

        run_job("rstjob", 1'b1, 0, 0, 1'b0, 300, c);
        @(posedge clk);
        #1;
        chk("post_rst_busy", int'(busy), 0);

        snap();
        run_job("reload", 1'b1, 0, 0, 1'b0, 0, c);
        job_checks("reload", 64);

        snap();
        run_job("gaps", 1'b1, 0, 1, 1'b0, 0, c);
        job_checks("gaps", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
